// File: rtl/pifo_stfq_rank.sv
// pifo_stfq_rank
//   Start-Time Fair Queueing rank stage that sits in front of pifo_base.
//   Each packet is ranked with start = max(vtime, finish[flow]). The flow's
//   finish time then advances by the packet cost and saturates at
//   MAX_PRIORITY-1. Virtual time follows the priorities that the PIFO
//   dequeues. A single output register holds the ranked packet until the
//   PIFO takes it.
//
// Optional feature (macro STFQ_WEIGHT_EN):
//   Adds a 3-bit shift per flow that is written through the cfg port.
//   The cost becomes len >> shift[flow], so a larger shift gives the flow
//   a heavier weight.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   i__pkt_*           upstream packet (valid/ready with o__pkt_ready)
//   o__rank_*          ranked packet towards the PIFO enqueue port
//   i__rank_ready      PIFO enqueue ready
//   i__deq_valid/prio  dequeue feedback that advances virtual time
//   i__cfg_*           per-flow shift write (STFQ_WEIGHT_EN only)
//   i__clear_all       synchronous flush, issued together with the PIFO clear
module pifo_stfq_rank #(
  parameter int NUM_FLOWS    = 8,
  parameter int MAX_PRIORITY = 256,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  localparam int FLOW_WIDTH  = $clog2(NUM_FLOWS),
  localparam int PRIO_WIDTH  = $clog2(MAX_PRIORITY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__pkt_valid,
  input  logic [FLOW_WIDTH-1:0] i__pkt_flow_id,
  input  logic [LEN_WIDTH-1:0]  i__pkt_len,
  input  logic [DATA_WIDTH-1:0] i__pkt_data,
  output logic                  o__pkt_ready,
  output logic                  o__rank_valid,
  output logic [PRIO_WIDTH-1:0] o__rank_priority,
  output logic [DATA_WIDTH-1:0] o__rank_data,
  input  logic                  i__rank_ready,
  input  logic                  i__deq_valid,
  input  logic [PRIO_WIDTH-1:0] i__deq_priority,
`ifdef STFQ_WEIGHT_EN
  input  logic                  i__cfg_wr_valid,
  input  logic [FLOW_WIDTH-1:0] i__cfg_flow_id,
  input  logic [2:0]            i__cfg_shift,
`endif
  input  logic                  i__clear_all
);

  // The extra bit on the sum keeps the carry, so saturation can always
  // detect an overflow.
  localparam int SUM_WIDTH = PRIO_WIDTH + LEN_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0]  RANK_MAX_W = SUM_WIDTH'(MAX_PRIORITY - 1);
  localparam logic [PRIO_WIDTH-1:0] RANK_MAX   = PRIO_WIDTH'(MAX_PRIORITY - 1);

  logic [PRIO_WIDTH-1:0] finish_q [NUM_FLOWS];
  logic [PRIO_WIDTH-1:0] vtime_q, vtime_d;
  logic                  rank_valid_q, rank_valid_d;
  logic [PRIO_WIDTH-1:0] rank_prio_q, rank_prio_d;
  logic [DATA_WIDTH-1:0] rank_data_q, rank_data_d;

  logic                  accept;
  logic [PRIO_WIDTH-1:0] finish_sel;
  logic [PRIO_WIDTH-1:0] start;
  logic [LEN_WIDTH-1:0]  inc;
  logic [SUM_WIDTH-1:0]  sum;
  logic [PRIO_WIDTH-1:0] finish_new;

`ifdef STFQ_WEIGHT_EN
  logic [2:0] shift_q [NUM_FLOWS];

  // Per-flow weight shifts. Only the async reset clears them; a flush keeps
  // the configuration. An accept in the same cycle still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) shift_q[f] <= '0;
    end else if (i__cfg_wr_valid) begin
      shift_q[i__cfg_flow_id] <= i__cfg_shift;
    end
  end
`endif

  // Handshake and rank arithmetic. The rank is taken from the registered
  // vtime, so a dequeue in the same cycle only affects later packets.
  always_comb begin
    o__pkt_ready = ~reset & ~i__clear_all & (~rank_valid_q | i__rank_ready);
    accept       = i__pkt_valid & o__pkt_ready;
    finish_sel   = finish_q[i__pkt_flow_id];
    start        = (finish_sel > vtime_q) ? finish_sel : vtime_q;
`ifdef STFQ_WEIGHT_EN
    inc          = i__pkt_len >> shift_q[i__pkt_flow_id];
`else
    inc          = i__pkt_len;
`endif
    sum          = SUM_WIDTH'(start) + SUM_WIDTH'(inc);
    finish_new   = (sum > RANK_MAX_W) ? RANK_MAX : sum[PRIO_WIDTH-1:0];
  end

  // Next state for the output entry and virtual time. A flush overrides
  // everything else in the cycle. An accept refills the entry in the same
  // cycle that the PIFO drains it.
  always_comb begin
    vtime_d      = vtime_q;
    rank_valid_d = rank_valid_q;
    rank_prio_d  = rank_prio_q;
    rank_data_d  = rank_data_q;
    if (i__deq_valid && (i__deq_priority > vtime_q)) vtime_d = i__deq_priority;
    if (i__rank_ready) rank_valid_d = 1'b0;
    if (accept) begin
      rank_valid_d = 1'b1;
      rank_prio_d  = start;
      rank_data_d  = i__pkt_data;
    end
    if (i__clear_all) begin
      rank_valid_d = 1'b0;
      vtime_d      = '0;
    end
  end

  // Output register and virtual time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtime_q      <= '0;
      rank_valid_q <= 1'b0;
      rank_prio_q  <= '0;
      rank_data_q  <= '0;
    end else begin
      vtime_q      <= vtime_d;
      rank_valid_q <= rank_valid_d;
      rank_prio_q  <= rank_prio_d;
      rank_data_q  <= rank_data_d;
    end
  end

  // Finish-time table. The accept path is disabled while a flush is active,
  // so the clear branch never competes with a table write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) finish_q[f] <= '0;
    end else if (i__clear_all) begin
      for (int f = 0; f < NUM_FLOWS; f++) finish_q[f] <= '0;
    end else if (accept) begin
      finish_q[i__pkt_flow_id] <= finish_new;
    end
  end

  assign o__rank_valid    = rank_valid_q;
  assign o__rank_priority = rank_prio_q;
  assign o__rank_data     = rank_data_q;

endmodule

// File: tb/tb_pifo_stfq_rank.sv
// tb_pifo_stfq_rank
//   Directed testbench for pifo_stfq_rank using the default parameters.
//   Every expected rank is worked out by hand from the STFQ rules.
//   Define STFQ_WEIGHT_EN to also exercise the per-flow weight shifts.
module tb_pifo_stfq_rank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [2:0] pkt_flow_id = '0;
  logic [7:0] pkt_len = '0;
  logic [7:0] pkt_data = '0;
  logic       pkt_ready;
  logic       rank_valid;
  logic [7:0] rank_priority;
  logic [7:0] rank_data;
  logic       rank_ready = 1'b1;
  logic       deq_valid = 1'b0;
  logic [7:0] deq_priority = '0;
  logic       clear_all = 1'b0;
`ifdef STFQ_WEIGHT_EN
  logic       cfg_wr_valid = 1'b0;
  logic [2:0] cfg_flow_id = '0;
  logic [2:0] cfg_shift = '0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pifo_stfq_rank dut (
    .clk              (clk),
    .reset            (reset),
    .i__pkt_valid     (pkt_valid),
    .i__pkt_flow_id   (pkt_flow_id),
    .i__pkt_len       (pkt_len),
    .i__pkt_data      (pkt_data),
    .o__pkt_ready     (pkt_ready),
    .o__rank_valid    (rank_valid),
    .o__rank_priority (rank_priority),
    .o__rank_data     (rank_data),
    .i__rank_ready    (rank_ready),
    .i__deq_valid     (deq_valid),
    .i__deq_priority  (deq_priority),
`ifdef STFQ_WEIGHT_EN
    .i__cfg_wr_valid  (cfg_wr_valid),
    .i__cfg_flow_id   (cfg_flow_id),
    .i__cfg_shift     (cfg_shift),
`endif
    .i__clear_all     (clear_all)
  );

  // Offer one packet at the falling edge. Returns 1 ns after the rising edge
  // that accepts it, with valid still high.
  task automatic send(input logic [2:0] flow, input logic [7:0] len, input logic [7:0] data);
    @(negedge clk);
    pkt_valid   = 1'b1;
    pkt_flow_id = flow;
    pkt_len     = len;
    pkt_data    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic deq(input logic [7:0] prio);
    @(negedge clk);
    pkt_valid    = 1'b0;
    deq_valid    = 1'b1;
    deq_priority = prio;
    @(posedge clk);
    #1;
    deq_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    deq_valid  = 1'b0;
    clear_all  = 1'b0;
    rank_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pkt_ready !== 1'b0 || rank_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got ready=%b valid=%b expected ready=0 valid=0", pkt_ready, rank_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", pkt_ready);
    end
    send(3'd5, 8'd3, 8'hAA);
    send(3'd5, 8'd3, 8'hAB);
    checks++;
    if (rank_valid !== 1'b1 || rank_priority !== 8'd3 || rank_data !== 8'hAB) begin
      errors++;
      $display("[TB] FAIL reset_pre_rank: got valid=%b prio=%0d data=%h expected valid=1 prio=3 data=ab", rank_valid, rank_priority, rank_data);
    end
    pkt_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rank_valid !== 1'b0 || rank_priority !== 8'd0 || rank_data !== 8'd0 || pkt_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got valid=%b prio=%0d data=%h ready=%b expected all 0", rank_valid, rank_priority, rank_data, pkt_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready_after: got %b expected 1", pkt_ready);
    end
    send(3'd5, 8'd1, 8'hAC);
    checks++;
    if (rank_priority !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_finish_cleared: got prio=%0d expected 0", rank_priority);
    end
  endtask

  task automatic test_single_flow();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(3'd2, 8'd10, 8'(8'h21 + i));
      checks++;
      if (rank_valid !== 1'b1 || rank_priority !== 8'(10 * i) || rank_data !== 8'(8'h21 + i)) begin
        errors++;
        $display("[TB] FAIL single_rank%0d: got valid=%b prio=%0d data=%h expected valid=1 prio=%0d data=%h",
                 i, rank_valid, rank_priority, rank_data, 10 * i, 8'(8'h21 + i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      send(3'd2, 8'd0, 8'(8'h24 + i));
      checks++;
      if (rank_priority !== 8'd30) begin
        errors++;
        $display("[TB] FAIL single_len0_%0d: got prio=%0d expected 30", i, rank_priority);
      end
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rank_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drain: got valid=%b expected 0", rank_valid);
    end
  endtask

  task automatic test_fairness();
    int flows [3] = '{0, 1, 0};
    int ranks [3] = '{0, 0, 40};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(3'(flows[i]), 8'd40, 8'(8'h30 + i));
      checks++;
      if (rank_priority !== 8'(ranks[i]) || rank_data !== 8'(8'h30 + i)) begin
        errors++;
        $display("[TB] FAIL fair_rank%0d: got prio=%0d data=%h expected prio=%0d data=%h",
                 i, rank_priority, rank_data, ranks[i], 8'(8'h30 + i));
      end
    end
  endtask

  task automatic test_vtime();
    logic [2:0] flows [4] = '{3'd3, 3'd3, 3'd4, 3'd6};
    logic [7:0] lens  [4] = '{8'd4, 8'd0, 8'd1, 8'd0};
    int         ranks [4] = '{50, 54, 50, 100};
    do_reset();
    send(3'd3, 8'd5, 8'h40);
    deq(8'd50);
    send(flows[0], lens[0], 8'h41);
    checks++;
    if (rank_priority !== 8'(ranks[0])) begin
      errors++;
      $display("[TB] FAIL vtime_rank: got prio=%0d expected %0d", rank_priority, ranks[0]);
    end
    send(flows[1], lens[1], 8'h42);
    checks++;
    if (rank_priority !== 8'(ranks[1])) begin
      errors++;
      $display("[TB] FAIL vtime_finish3: got prio=%0d expected %0d", rank_priority, ranks[1]);
    end
    deq(8'd20);
    send(flows[2], lens[2], 8'h43);
    checks++;
    if (rank_priority !== 8'(ranks[2])) begin
      errors++;
      $display("[TB] FAIL vtime_monotonic: got prio=%0d expected %0d", rank_priority, ranks[2]);
    end
    // Accept and dequeue in the same cycle: the rank uses the old vtime.
    @(negedge clk);
    pkt_valid    = 1'b1;
    pkt_flow_id  = 3'd5;
    pkt_len      = 8'd2;
    pkt_data     = 8'h44;
    deq_valid    = 1'b1;
    deq_priority = 8'd100;
    @(posedge clk);
    #1;
    deq_valid = 1'b0;
    checks++;
    if (rank_priority !== 8'd50 || rank_data !== 8'h44) begin
      errors++;
      $display("[TB] FAIL vtime_same_cycle: got prio=%0d data=%h expected prio=50 data=44", rank_priority, rank_data);
    end
    send(flows[3], lens[3], 8'h45);
    checks++;
    if (rank_priority !== 8'(ranks[3])) begin
      errors++;
      $display("[TB] FAIL vtime_after_same_cycle: got prio=%0d expected %0d", rank_priority, ranks[3]);
    end
  endtask

  task automatic test_backpressure_saturation();
    do_reset();
    send(3'd1, 8'd250, 8'h51);
    @(negedge clk);
    rank_ready  = 1'b0;
    pkt_flow_id = 3'd1;
    pkt_len     = 8'd20;
    pkt_data    = 8'h52;
    #1;
    checks++;
    if (pkt_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_ready_low: got %b expected 0", pkt_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rank_valid !== 1'b1 || rank_priority !== 8'd0 || rank_data !== 8'h51) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b prio=%0d data=%h expected valid=1 prio=0 data=51",
                 i, rank_valid, rank_priority, rank_data);
      end
    end
    @(negedge clk);
    rank_ready = 1'b1;
    #1;
    checks++;
    if (pkt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_high: got %b expected 1", pkt_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rank_priority !== 8'd250 || rank_data !== 8'h52) begin
      errors++;
      $display("[TB] FAIL bp_release: got prio=%0d data=%h expected prio=250 data=52", rank_priority, rank_data);
    end
    for (int i = 0; i < 2; i++) begin
      send(3'd1, 8'(5 - 5 * i), 8'(8'h53 + i));
      checks++;
      if (rank_priority !== 8'd255) begin
        errors++;
        $display("[TB] FAIL sat_rank%0d: got prio=%0d expected 255", i, rank_priority);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
`ifdef STFQ_WEIGHT_EN
    @(negedge clk);
    cfg_wr_valid = 1'b1;
    cfg_flow_id  = 3'd0;
    cfg_shift    = 3'd1;
    @(posedge clk);
    #1;
    cfg_wr_valid = 1'b0;
`endif
    deq(8'd10);
    send(3'd0, 8'd30, 8'h61);
    checks++;
    if (rank_priority !== 8'd10) begin
      errors++;
      $display("[TB] FAIL clear_pre_rank: got prio=%0d expected 10", rank_priority);
    end
    @(negedge clk);
    rank_ready  = 1'b0;
    clear_all   = 1'b1;
    pkt_flow_id = 3'd1;
    pkt_len     = 8'd9;
    pkt_data    = 8'h62;
    #1;
    checks++;
    if (pkt_ready !== 1'b0 || rank_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_ready: got ready=%b valid=%b expected ready=0 valid=1", pkt_ready, rank_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rank_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_valid: got %b expected 0", rank_valid);
    end
    @(negedge clk);
    clear_all  = 1'b0;
    rank_ready = 1'b1;
    pkt_valid  = 1'b0;
`ifdef STFQ_WEIGHT_EN
    send(3'd0, 8'd8, 8'h63);
    checks++;
    if (rank_priority !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wt_rank0: got prio=%0d expected 0", rank_priority);
    end
    send(3'd0, 8'd8, 8'h64);
    checks++;
    if (rank_priority !== 8'd4) begin
      errors++;
      $display("[TB] FAIL wt_rank1: got prio=%0d expected 4", rank_priority);
    end
    // A cfg write in the same cycle as an accept: the accept still uses shift 1.
    @(negedge clk);
    cfg_wr_valid = 1'b1;
    cfg_flow_id  = 3'd0;
    cfg_shift    = 3'd2;
    pkt_data     = 8'h65;
    @(posedge clk);
    #1;
    cfg_wr_valid = 1'b0;
    checks++;
    if (rank_priority !== 8'd8) begin
      errors++;
      $display("[TB] FAIL wt_same_cycle: got prio=%0d expected 8", rank_priority);
    end
    send(3'd0, 8'd8, 8'h66);
    checks++;
    if (rank_priority !== 8'd12) begin
      errors++;
      $display("[TB] FAIL wt_old_shift: got prio=%0d expected 12", rank_priority);
    end
    send(3'd0, 8'd0, 8'h67);
    checks++;
    if (rank_priority !== 8'd14) begin
      errors++;
      $display("[TB] FAIL wt_new_shift: got prio=%0d expected 14", rank_priority);
    end
`else
    send(3'd0, 8'd7, 8'h63);
    checks++;
    if (rank_priority !== 8'd0 || rank_data !== 8'h63) begin
      errors++;
      $display("[TB] FAIL clear_rank0: got prio=%0d data=%h expected prio=0 data=63", rank_priority, rank_data);
    end
    send(3'd0, 8'd7, 8'h64);
    checks++;
    if (rank_priority !== 8'd7) begin
      errors++;
      $display("[TB] FAIL clear_rank1: got prio=%0d expected 7", rank_priority);
    end
`endif
    send(3'd1, 8'd3, 8'h68);
    checks++;
    if (rank_priority !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clear_vtime: got prio=%0d expected 0", rank_priority);
    end
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_flow();
    test_fairness();
    test_vtime();
    test_backpressure_saturation();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
